serial_pattern_tx: RTL

Serial pattern transmitter: the sending end of the single-bit serial stream that the team's sequence detectors consume.
- Captures a programmable bit pattern on a start handshake.
- Shifts it out MSB-first, one bit per clk, on a registered serial line with a qualifying valid.
- Repeats the frame a programmable number of times, with an idle gap between frames.
- Used as stimulus and as a link driver in front of the pattern-detector blocks.

---
 rtl/serial_pattern_pkg.sv | 14 +
 rtl/pattern_shifter.sv | 40 ++++
 rtl/serial_pattern_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// The optional parity cycle is enabled by defining SERIAL_PATTERN_TX_PARITY_EN.
package serial_pattern_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    localparam logic [5:0] DEFAULT_PATTERN = 6'b110101;

    // Frame length minus one, limited to what the pattern register can hold.
    function automatic int clamp_len_m1(input int len_m1, input int pat_w);
        return (len_m1 >= pat_w) ? pat_w - 1 : len_m1;
    endfunction

endpackage

// File: rtl/pattern_shifter.sv
// Loadable MSB-first shift register with a bit down-counter.
// last_bit is high while the final bit of the loaded field sits at the MSB.
module pattern_shifter #(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len_m1,
    output logic             msb,
    output logic             last_bit
);

    logic [PAT_W-1:0] shreg;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] shamt;

    // Left-align the active field so its top bit lands on the MSB.
    assign shamt = LEN_W'(PAT_W - 1) - len_m1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= pattern << shamt;
            bit_cnt <= len_m1;
        end else if (shift) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    assign msb      = shreg[PAT_W-1];
    assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with idle gaps.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_done
);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] lm1_q;
    logic [LEN_W-1:0] lm1_c;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic             accept;
    logic             reload;
    logic             load;
    logic             shift;
    logic             msb;
    logic             last_bit;
    logic             frame_last;
    logic             tx_bit;
    logic [PAT_W-1:0] ld_pat;
    logic [LEN_W-1:0] ld_lm1;

    assign lm1_c  = LEN_W'(clamp_len_m1(int'(len_m1), PAT_W));
    assign accept = (state == IDLE) && ready && start;
    // Reload either straight after a frame (no gap) or on the final gap cycle.
    assign reload = ((state == SHIFT) && frame_last && (frame_cnt != '0) && (gap_q == '0))
                 || ((state == GAP) && (gap_cnt == GAP_W'(1)));
    assign load   = accept || reload;
    assign ld_pat = accept ? pattern : pat_q;
    assign ld_lm1 = accept ? lm1_c : lm1_q;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic par_phase;
    logic par_acc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_phase <= 1'b0;
            par_acc   <= 1'b0;
        end else if (state == SHIFT) begin
            if (par_phase) begin
                par_phase <= 1'b0;
                par_acc   <= 1'b0;
            end else begin
                par_acc <= par_acc ^ msb;
                if (last_bit) par_phase <= 1'b1;
            end
        end
    end

    assign shift      = (state == SHIFT) && !par_phase;
    assign frame_last = par_phase;
    assign tx_bit     = par_phase ? par_acc : msb;
`else
    assign shift      = (state == SHIFT);
    assign frame_last = last_bit;
    assign tx_bit     = msb;
`endif

    pattern_shifter #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_shifter (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .shift   (shift),
        .pattern (ld_pat),
        .len_m1  (ld_lm1),
        .msb     (msb),
        .last_bit(last_bit)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            ready      <= 1'b1;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            pat_q      <= PAT_W'(DEFAULT_PATTERN);
            lm1_q      <= '0;
            gap_q      <= '0;
            frame_cnt  <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    ready     <= 1'b1;
                    if (accept) begin
                        pat_q     <= pattern;
                        lm1_q     <= lm1_c;
                        gap_q     <= gap;
                        frame_cnt <= repeat_n;
                        ready     <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    out       <= tx_bit;
                    out_valid <= 1'b1;
                    if (frame_last) begin
                        if (frame_cnt != '0) begin
                            frame_cnt <= frame_cnt - 1'b1;
                            if (gap_q != '0) begin
                                gap_cnt <= gap_q;
                                state   <= GAP;
                            end
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                GAP: begin
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    gap_cnt   <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1)) state <= SHIFT;
                end
                DONE: begin
                    out        <= 1'b0;
                    out_valid  <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
